// File: rtl/life_display_pkg.sv
// Shared types and constants for the Life VGA cell renderer: palette,
// cell transition codes and the stage-1 sideband bundle.
package life_display_pkg;

  localparam logic [11:0] COL_DEAD   = 12'h000;
  localparam logic [11:0] COL_ALIVE  = 12'h0F0;
  localparam logic [11:0] COL_BORN   = 12'hFF0;
  localparam logic [11:0] COL_DIED   = 12'hF00;
  localparam logic [11:0] COL_GRID   = 12'h333;
  localparam logic [11:0] COL_CURSOR = 12'hFFF;

  // Encoded as {was_alive, alive} so the RAM outputs concatenate straight into it.
  typedef enum logic [1:0] {
    DEAD       = 2'b00,
    JUST_ALIVE = 2'b01,
    JUST_DEAD  = 2'b10,
    ALIVE      = 2'b11
  } cell_state_e;

  typedef struct packed {
    logic valid;
    logic in_range;
    logic grid_line;
    logic cursor_edge;
  } s1_side_t;

  function automatic logic [11:0] cell_colour(input cell_state_e st, input logic fade_on);
    case (st)
      JUST_ALIVE: return fade_on ? COL_BORN : COL_ALIVE;
      JUST_DEAD:  return fade_on ? COL_DIED : COL_DEAD;
      ALIVE:      return COL_ALIVE;
      default:    return COL_DEAD;
    endcase
  endfunction

endpackage

// File: rtl/frame_fx_timer.sv
// Frame-rate effect timers: transition fade countdown after each generation
// step, and the cursor blink phase.
module frame_fx_timer #(
  parameter int FADE_FRAMES  = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic gen_step,
  output logic fade_on,
  output logic blink
);

  localparam logic [7:0] FADE_LOAD  = 8'(FADE_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] fade_cnt_q, fade_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       blink_q, blink_d;

  // NOTE: every variable gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fade_cnt_d  = fade_cnt_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    // A new generation restarts the fade even on a frame boundary.
    if (gen_step) begin
      fade_cnt_d = FADE_LOAD;
    end else if (frame_start && fade_cnt_q != 8'd0) begin
      fade_cnt_d = fade_cnt_q - 8'd1;
    end
    if (frame_start) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_cnt_q  <= 8'd0;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      fade_cnt_q  <= fade_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign fade_on = (fade_cnt_q != 8'd0);
  assign blink   = blink_q;

endmodule

// File: rtl/life_display_pipe.sv
// Two-stage pixel-to-colour pipeline for the Life display: stage 1 maps x/y to
// a cell address and issues the RAM read, stage 2 picks the colour.
module life_display_pipe
  import life_display_pkg::*;
#(
  parameter int COORD_W      = 11,
  parameter int CELL_SHIFT   = 7,
  parameter int COL_BITS     = 2,
  parameter int ROW_BITS     = 2,
  parameter int GRID_X0      = 0,
  parameter int GRID_Y0      = 0,
  parameter int FADE_FRAMES  = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pix_valid,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic                         frame_start,
  input  logic                         gen_step,
  output logic                         cell_rd_en,
  output logic [COL_BITS+ROW_BITS-1:0] cell_addr,
  input  logic                         cell_alive,
  input  logic                         cell_was_alive,
  input  logic                         grid_en,
  input  logic                         cursor_en,
  input  logic [COL_BITS-1:0]          cursor_col,
  input  logic [ROW_BITS-1:0]          cursor_row,
  output logic                         rgb_valid,
  output logic [11:0]                  rgb
);

  localparam int ADDR_W = COL_BITS + ROW_BITS;
  localparam logic [COORD_W:0] X0     = (COORD_W+1)'(GRID_X0);
  localparam logic [COORD_W:0] Y0     = (COORD_W+1)'(GRID_Y0);
  localparam logic [COORD_W:0] GRID_W = (COORD_W+1)'(1 << (CELL_SHIFT + COL_BITS));
  localparam logic [COORD_W:0] GRID_H = (COORD_W+1)'(1 << (CELL_SHIFT + ROW_BITS));

  logic                  fade_on, blink;
  logic [COORD_W:0]      dx, dy;
  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic [CELL_SHIFT-1:0] lx, ly;
  logic                  in_range, on_edge;

  s1_side_t          s1_q, s1_d;
  logic              cell_rd_en_q, cell_rd_en_d;
  logic [ADDR_W-1:0] cell_addr_q, cell_addr_d;
  logic              rgb_valid_q;
  logic [11:0]       rgb_q, rgb_d;

  frame_fx_timer #(
    .FADE_FRAMES (FADE_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_fx (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .gen_step   (gen_step),
    .fade_on    (fade_on),
    .blink      (blink)
  );

  // One extra bit makes left/above-origin pixels come out negative.
  assign dx  = {1'b0, x} - X0;
  assign dy  = {1'b0, y} - Y0;
  assign col = dx[CELL_SHIFT +: COL_BITS];
  assign row = dy[CELL_SHIFT +: ROW_BITS];
  assign lx  = dx[CELL_SHIFT-1:0];
  assign ly  = dy[CELL_SHIFT-1:0];

  assign in_range = !dx[COORD_W] && !dy[COORD_W] && (dx < GRID_W) && (dy < GRID_H);
  assign on_edge  = (lx == '0) || (lx == '1) || (ly == '0) || (ly == '1);

  always_comb begin
    s1_d             = '0;
    s1_d.valid       = pix_valid;
    s1_d.in_range    = in_range;
    s1_d.grid_line   = grid_en && on_edge;
    s1_d.cursor_edge = cursor_en && on_edge && (col == cursor_col) && (row == cursor_row);
    cell_rd_en_d     = pix_valid && in_range;
    cell_addr_d      = cell_rd_en_d ? {col, row} : cell_addr_q;
  end

  // The RAM answers during the cycle after the strobe, so its data lines up with s1_q here.
  always_comb begin
    rgb_d = COL_DEAD;
    if (!s1_q.valid || !s1_q.in_range) begin
      rgb_d = COL_DEAD;
    end else if (s1_q.cursor_edge && blink) begin
      rgb_d = COL_CURSOR;
    end else if (s1_q.grid_line) begin
      rgb_d = COL_GRID;
    end else begin
      rgb_d = cell_colour(cell_state_e'({cell_was_alive, cell_alive}), fade_on);
    end
  end

  // Release is expected synchronous upstream; a local synchroniser would swallow the first pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      cell_rd_en_q <= 1'b0;
      cell_addr_q  <= '0;
      rgb_valid_q  <= 1'b0;
      rgb_q        <= COL_DEAD;
    end else begin
      s1_q         <= s1_d;
      cell_rd_en_q <= cell_rd_en_d;
      cell_addr_q  <= cell_addr_d;
      rgb_valid_q  <= s1_q.valid;
      rgb_q        <= rgb_d;
    end
  end

  assign cell_rd_en = cell_rd_en_q;
  assign cell_addr  = cell_addr_q;
  assign rgb_valid  = rgb_valid_q;
  assign rgb        = rgb_q;

endmodule

// File: tb/tb_life_display_pipe.sv
// Scoreboard bench for life_display_pipe: two instances (origin 0,0 and 64,32)
// share stimulus and a cell RAM model; a reference model predicts every pixel.
module tb_life_display_pipe;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0, frame_start = 1'b0, gen_step = 1'b0;
  logic        grid_en = 1'b0, cursor_en = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic [1:0]  cursor_col = '0, cursor_row = '0;

  logic        rd_en     [N];
  logic [3:0]  addr      [N];
  logic        alive     [N];
  logic        was       [N];
  logic        rgb_valid [N];
  logic [11:0] rgb       [N];

  bit [1:0] mem [16];   // {was_alive, alive}, address {col,row}

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    life_display_pipe #(.GRID_X0(g * 64), .GRID_Y0(g * 32)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pix_valid     (pix_valid),
      .x             (x),
      .y             (y),
      .frame_start   (frame_start),
      .gen_step      (gen_step),
      .cell_rd_en    (rd_en[g]),
      .cell_addr     (addr[g]),
      .cell_alive    (alive[g]),
      .cell_was_alive(was[g]),
      .grid_en       (grid_en),
      .cursor_en     (cursor_en),
      .cursor_col    (cursor_col),
      .cursor_row    (cursor_row),
      .rgb_valid     (rgb_valid[g]),
      .rgb           (rgb[g])
    );
    // RAM data is sampled by the edge after the strobe
    assign alive[g] = mem[addr[g]][0];
    assign was[g]   = mem[addr[g]][1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference colour straight from the rendering rules.
  function automatic logic [11:0] ref_rgb(input int x0, input int y0, input int px, input int py,
                                          input bit grid, input bit cen, input int ccol, input int crow,
                                          input bit fade_on, input bit blink);
    int dx = px - x0;
    int dy = py - y0;
    int col, row, ox, oy;
    bit on_edge;
    bit [1:0] st;
    if (dx < 0 || dy < 0 || dx >= 512 || dy >= 512) return 12'h000;
    col = dx / 128;  row = dy / 128;
    ox  = dx % 128;  oy  = dy % 128;
    on_edge = (ox == 0) || (ox == 127) || (oy == 0) || (oy == 127);
    if (cen && col == ccol && row == crow && on_edge && blink) return 12'hFFF;
    if (grid && on_edge) return 12'h333;
    st = mem[col * 4 + row];
    case (st)
      2'b00:   return 12'h000;
      2'b11:   return 12'h0F0;
      2'b10:   return fade_on ? 12'hF00 : 12'h000;
      default: return fade_on ? 12'hFF0 : 12'h0F0;
    endcase
  endfunction

  // Reference model: a pixel accepted at one edge is coloured with the RAM and
  // frame effects as they stand at the following edge.
  int          fade_left, frame_no, pend_x, pend_y, pend_ccol, pend_crow;
  bit          pend_v, pend_grid, pend_cen;
  logic [11:0] exp_q0 [$];
  logic [11:0] exp_q1 [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      fade_left <= 0;
      frame_no  <= 0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (pend_v) begin
        exp_q0.push_back(ref_rgb(0, 0, pend_x, pend_y, pend_grid, pend_cen, pend_ccol, pend_crow,
                                 fade_left != 0, ((frame_no / 16) % 2) == 1));
        exp_q1.push_back(ref_rgb(64, 32, pend_x, pend_y, pend_grid, pend_cen, pend_ccol, pend_crow,
                                 fade_left != 0, ((frame_no / 16) % 2) == 1));
      end
      if (gen_step) fade_left <= 8;
      else if (frame_start && fade_left > 0) fade_left <= fade_left - 1;
      if (frame_start) frame_no <= frame_no + 1;
      pend_v    <= pix_valid;
      pend_x    <= int'(x);
      pend_y    <= int'(y);
      pend_grid <= grid_en;
      pend_cen  <= cursor_en;
      pend_ccol <= int'(cursor_col);
      pend_crow <= int'(cursor_row);
    end
  end

  // Monitor: pop and compare on every presented pixel; bubbles must be black.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < N; g++) begin
        logic [11:0] e;
        bit have;
        have = 1'b0;
        e    = '0;
        if (g == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
        if (g == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
        if (rgb_valid[g]) begin
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL sb%0d_unexpected: got pixel %0h expected no pixel", g, rgb[g]);
          end else begin
            check($sformatf("sb%0d_rgb x=%0d y=%0d", g, x, y), rgb[g], e);
          end
        end else begin
          if (have) begin
            checks++;
            errors++;
            $display("FAIL sb%0d_missing: got no pixel expected %0h", g, e);
          end
          check($sformatf("sb%0d_bubble_rgb", g), rgb[g], 12'h000);
        end
      end
    end
  end

  task automatic probe(input int g, input int px, input int py, input logic [11:0] exp, input string name);
    x = 11'(px);
    y = 11'(py);
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, rgb_valid[g], 1);
    check(name, rgb[g], exp);
  endtask

  task automatic frames(input int n, input bit gs);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      gen_step    = gs;
      @(negedge clk);
      frame_start = 1'b0;
      gen_step    = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic gen_pulse();
    gen_step = 1'b1;
    @(negedge clk);
    gen_step = 1'b0;
  endtask

  task automatic reset_dut();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream, then the first pixel after release
    x = 11'd300; y = 11'd130; pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_valid", rgb_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst%0d_rgb", g), rgb[g], 0);
      check($sformatf("rst%0d_rgb_valid", g), rgb_valid[g], 0);
      check($sformatf("rst%0d_rd_en", g), rd_en[g], 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_stale", rgb_valid[0], 0);
    @(posedge clk); #1;
    check("post_rst_latency2", rgb_valid[0], 1);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Addressing with default origin
    x = 11'd300; y = 11'd130; pix_valid = 1'b1;
    @(posedge clk); #1;
    check("addr_300_130", addr[0], 4'b1001);
    check("rd_en_in_range", rd_en[0], 1);
    @(negedge clk);
    x = 11'd600; y = 11'd0;
    @(posedge clk); #1;
    check("rd_en_out_of_range", rd_en[0], 0);
    check("addr_holds", addr[0], 4'b1001);
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    check("oor_valid", rgb_valid[0], 1);
    check("oor_rgb", rgb[0], 12'h000);
    @(negedge clk);

    // Grid and blinking cursor from a known blink phase
    reset_dut();
    grid_en = 1'b1;
    probe(0, 128, 50, 12'h333, "grid_line");
    cursor_en = 1'b1; cursor_col = 2'd1; cursor_row = 2'd0;
    probe(0, 128, 50, 12'h333, "cursor_blink_off");
    frames(16, 1'b0);
    probe(0, 128, 50, 12'hFFF, "cursor_blink_on");
    frames(16, 1'b0);
    probe(0, 128, 50, 12'h333, "cursor_blink_off_again");
    grid_en = 1'b0; cursor_en = 1'b0;

    // Born and died fades
    mem[0] = 2'b01;
    gen_pulse();
    probe(0, 50, 50, 12'hFF0, "born_fade_start");
    frames(7, 1'b0);
    probe(0, 50, 50, 12'hFF0, "born_fade_7");
    frames(1, 1'b0);
    probe(0, 50, 50, 12'h0F0, "born_fade_done");
    mem[0] = 2'b10;
    gen_pulse();
    probe(0, 50, 50, 12'hF00, "died_fade_start");
    frames(8, 1'b0);
    probe(0, 50, 50, 12'h000, "died_fade_done");

    // gen_step and frame_start together: reload wins
    mem[0] = 2'b01;
    gen_pulse();
    frames(5, 1'b0);
    frames(1, 1'b1);
    frames(7, 1'b0);
    probe(0, 50, 50, 12'hFF0, "collision_hold");
    frames(1, 1'b0);
    probe(0, 50, 50, 12'h0F0, "collision_expire");

    // Shifted origin instance
    probe(1, 63, 40, 12'h000, "origin_left_oor");
    x = 11'd64; y = 11'd32; pix_valid = 1'b1;
    @(posedge clk); #1;
    check("origin_addr", addr[1], 4'b0000);
    check("origin_rd_en", rd_en[1], 1);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 22; i++) begin
      pix_valid = (i < 20);
      x = 11'(64 + i * 20);
      y = 11'd40;
      @(negedge clk);
      if (i >= 1 && i <= 20 && rgb_valid[1]) cnt++;
    end
    check("back_to_back_valid", cnt, 20);

    // Randomised stream, edges biased
    for (int i = 0; i < 3000; i++) begin
      pix_valid   = ($urandom_range(0, 9) < 8);
      frame_start = ($urandom_range(0, 29) == 0);
      gen_step    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) begin
        x = 11'($urandom_range(0, 700));
        y = 11'($urandom_range(0, 620));
      end else begin
        x = 11'($urandom_range(0, 4) * 128 + $urandom_range(0, 1) * 64 + ($urandom_range(0, 1) == 1 ? 127 : 0));
        y = 11'($urandom_range(0, 4) * 128 + $urandom_range(0, 1) * 32 + ($urandom_range(0, 1) == 1 ? 127 : 0));
      end
      if ($urandom_range(0, 199) == 0) begin
        grid_en    = 1'($urandom_range(0, 1));
        cursor_en  = 1'($urandom_range(0, 1));
        cursor_col = 2'($urandom_range(0, 3));
        cursor_row = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) mem[$urandom_range(0, 15)] = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    pix_valid = 1'b0; frame_start = 1'b0; gen_step = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
